// File: rtl/spi_flash_pkg.sv
// Shared constants and FSM encoding for the W25Q16 SPI read master.
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         ADDR_BITS     = 24;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CS_SETUP = 4'd1,
    ST_CMD      = 4'd2,
    ST_ADDR     = 4'd3,
    ST_DUMMY    = 4'd4,
    ST_DATA     = 4'd5,
    ST_WAIT     = 4'd6,
    ST_CS_HOLD  = 4'd7,
    ST_CS_IDLE  = 4'd8
  } state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
// Strobes mark the last cycle of each phase; disabling parks SCLK low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign sclk     = phase;
  assign rise_stb = !phase && (cnt == LAST);
  assign fall_stb =  phase && (cnt == LAST);
endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 read master for W25Q16: 03h + 24-bit address, then bytes out on valid/ready.
// Define SPI_FAST_READ_EN to issue 0Bh with 8 dummy SCLK cycles before data.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_start,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [LEN_W-1:0]     rd_len,
  output logic                 rd_busy,
  output logic                 rd_done,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 spi_clk,
  output logic                 cs,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE = CMD_FAST_READ;
`else
  localparam logic [7:0] OPCODE = CMD_READ;
`endif
  localparam logic [7:0] DLY_LAST = 8'(CLK_DIV - 1);

  state_t                 state, state_nxt;
  logic [7:0]             dly_cnt, dly_cnt_nxt;
  logic [4:0]             bit_cnt, bit_cnt_nxt;
  logic [ADDR_BITS+7:0]   tx_sr, tx_sr_nxt;
  logic [7:0]             rx_sr, rx_sr_nxt, rx_byte, rx_data_nxt;
  logic [LEN_W-1:0]       remain, remain_nxt;
  logic cs_nxt, mosi_nxt, busy_nxt, done_nxt, rx_valid_nxt;
  logic sclk_en, rise_stb, fall_stb, room, dly_end;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst(rst), .en(sclk_en),
    .sclk(spi_clk), .rise_stb(rise_stb), .fall_stb(fall_stb)
  );

  // Output register has room if empty or being drained this cycle.
  assign room    = !rx_valid || rx_ready;
  assign dly_end = (dly_cnt == DLY_LAST);
  assign rx_byte = {rx_sr[6:0], spi_miso};

  always_comb begin
    state_nxt    = state;
    dly_cnt_nxt  = dly_cnt;
    bit_cnt_nxt  = bit_cnt;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    remain_nxt   = remain;
    cs_nxt       = cs;
    mosi_nxt     = spi_mosi;
    busy_nxt     = rd_busy;
    done_nxt     = 1'b0;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = rx_valid && !rx_ready;
    sclk_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_done) begin
          busy_nxt = 1'b0;
        end else if (rd_start && !rd_busy) begin
          busy_nxt = 1'b1;
          if (rd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt   = ST_CS_SETUP;
            cs_nxt      = 1'b0;
            tx_sr_nxt   = {OPCODE, rd_addr};
            remain_nxt  = rd_len;
            dly_cnt_nxt = '0;
          end
        end
      end
      ST_CS_SETUP: begin
        if (dly_end) begin
          state_nxt   = ST_CMD;
          dly_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          mosi_nxt    = tx_sr[ADDR_BITS+7];
        end else begin
          dly_cnt_nxt = dly_cnt + 8'd1;
        end
      end
      ST_CMD, ST_ADDR: begin
        sclk_en = 1'b1;
        if (fall_stb) begin
          tx_sr_nxt   = tx_sr << 1;
          mosi_nxt    = tx_sr[ADDR_BITS+6];
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (state == ST_CMD && bit_cnt == 5'd7) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = '0;
          end else if (state == ST_ADDR && bit_cnt == 5'(ADDR_BITS - 1)) begin
            mosi_nxt    = 1'b0;
            bit_cnt_nxt = '0;
`ifdef SPI_FAST_READ_EN
            state_nxt   = ST_DUMMY;
`else
            state_nxt   = ST_DATA;
`endif
          end
        end
      end
      ST_DUMMY: begin
        sclk_en = 1'b1;
        if (fall_stb) begin
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
      end
      ST_DATA: begin
        sclk_en = 1'b1;
        // Hold off the first rising edge of a byte until its landing slot is free.
        if (rise_stb && bit_cnt == 5'd0 && !room) begin
          state_nxt = ST_WAIT;
          sclk_en   = 1'b0;
        end
        if (fall_stb) begin
          rx_sr_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt  = '0;
            rx_data_nxt  = rx_byte;
            rx_valid_nxt = 1'b1;
            remain_nxt   = remain - LEN_W'(1);
            if (remain == LEN_W'(1)) begin
              state_nxt   = ST_CS_HOLD;
              dly_cnt_nxt = '0;
            end
          end
        end
      end
      ST_WAIT: begin
        if (room) state_nxt = ST_DATA;
      end
      ST_CS_HOLD: begin
        if (dly_end) begin
          state_nxt   = ST_CS_IDLE;
          cs_nxt      = 1'b1;
          dly_cnt_nxt = '0;
        end else begin
          dly_cnt_nxt = dly_cnt + 8'd1;
        end
      end
      ST_CS_IDLE: begin
        if (dly_end) begin
          state_nxt   = ST_IDLE;
          done_nxt    = 1'b1;
          dly_cnt_nxt = '0;
        end else begin
          dly_cnt_nxt = dly_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dly_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      remain   <= '0;
      cs       <= 1'b1;
      spi_mosi <= 1'b0;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly_cnt  <= dly_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      remain   <= remain_nxt;
      cs       <= cs_nxt;
      spi_mosi <= mosi_nxt;
      rd_busy  <= busy_nxt;
      rd_done  <= done_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a W25Q16 read model and a byte scoreboard.
module tb_spi_flash_reader;
  localparam int D = 2;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int HDR   = 40;
  localparam int FIRST = 1 + 97 * D;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int HDR   = 32;
  localparam int FIRST = 1 + 81 * D;
`endif
  localparam int DONE = FIRST + 2 * D;
  localparam int BYTE = 16 * D;

  typedef struct { logic [7:0] d; int c; } obs_t;

  logic        clk = 1'b0;
  logic        rst, rd_start, rx_ready;
  logic [23:0] rd_addr;
  logic [15:0] rd_len;
  logic        rd_busy, rd_done, rx_valid, spi_clk, cs, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [7:0]  rx_data;

  int errs = 0, checks = 0, cyc = 0, t0 = 0;
  int done_cnt = 0, tot_rises = 0, rise_cnt = 0, last_rises = 0, stall_bad = 0;
  int j;
  logic [31:0] cmd_word = '0;
  logic [7:0]  mbytes [0:7];
  logic [7:0]  exp_q [$];
  obs_t        obs_q [$];

  spi_flash_reader #(.CLK_DIV(D), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .spi_clk(spi_clk), .cs(cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: capture MOSI on rising SCLK, present data bits for the high phase.
  always @(posedge spi_clk or posedge cs) begin
    if (cs) begin
      last_rises = rise_cnt;
      rise_cnt   = 0;
    end else begin
      tot_rises++;
      if (rise_cnt < 32) cmd_word = {cmd_word[30:0], spi_mosi};
      if (rise_cnt >= HDR) begin
        j = rise_cnt - HDR;
        if (j / 8 < 8) spi_miso <= mbytes[j / 8][7 - (j % 8)];
      end
      rise_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rx_valid && rx_ready) obs_q.push_back('{rx_data, cyc});
    if (rd_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_bytes(input logic [31:0] w, input int n, input bit push);
    for (int i = 0; i < 4; i++) mbytes[i] = w[31 - 8 * i -: 8];
    if (push) for (int i = 0; i < n; i++) exp_q.push_back(w[31 - 8 * i -: 8]);
  endtask

  task automatic start(input logic [23:0] a, input logic [15:0] n);
    rd_addr = a; rd_len = n; rd_start = 1'b1;
    t0 = cyc;
    step();
    rd_start = 1'b0;
  endtask

  task automatic wait_obs(input int n, input string tag);
    int k = 0;
    while (obs_q.size() < n && k < 3000) begin step(); k++; end
    chk(tag, obs_q.size() >= n, 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (rd_done !== 1'b1 && k < 3000) begin step(); k++; end
    chk(tag, rd_done, 1);
  endtask

  task automatic check_bytes(input int n, input bit timed, input string tag);
    obs_t o;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      if (obs_q.size() == 0 || exp_q.size() == 0) break;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_data%0d", tag, i), o.d, e);
      if (timed) chk($sformatf("%s_cyc%0d", tag, i), o.c - t0, FIRST + i * BYTE);
    end
  endtask

  initial begin
    int r0, d0;
    rst = 1'b1; rd_start = 1'b0; rd_addr = '0; rd_len = '0; rx_ready = 1'b1;
    repeat (3) step();
    chk("rst_cs", cs, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_done", rd_done, 0);
    rst = 1'b0;
    step();

    // Single byte read, timing of data and done.
    set_bytes(32'hA500_0000, 1, 1);
    start(24'h001234, 1);
    chk("t1_busy_c1", rd_busy, 1);
    chk("t1_cs_c1", cs, 0);
    wait_obs(1, "t1_tmo");
    check_bytes(1, 1, "t1");
    wait_done("t1_done_tmo");
    chk("t1_done_cyc", cyc - t0, DONE);
    chk("t1_done_busy", rd_busy, 1);
    step();
    chk("t1_busy_fall", rd_busy, 0);
    chk("t1_cmd", cmd_word, {OPC, 24'h001234});
    repeat (20) step();
    chk("t1_done_once", done_cnt, 1);
    chk("t1_cs_high", cs, 1);

    // Four back-to-back bytes, wrapping address, ignored start while busy.
    set_bytes(32'h0180_FF3C, 4, 1);
    start(24'hFFFFFE, 4);
    repeat (8) step();
    rd_addr = 24'h000055; rd_len = 16'd0; rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    wait_obs(4, "t2_tmo");
    check_bytes(4, 1, "t2");
    wait_done("t2_done_tmo");
    step();
    chk("t2_done_cnt", done_cnt, 2);
    chk("t2_cmd", cmd_word, {OPC, 24'hFFFFFE});
    chk("t2_data_rises", last_rises - HDR, 32);

    // Consumer stall after first byte.
    rx_ready = 1'b0;
    set_bytes(32'h1122_3300, 3, 1);
    start(24'h000100, 3);
    begin
      int k = 0;
      while (rx_valid !== 1'b1 && k < 3000) begin step(); k++; end
      chk("t3_first_valid", rx_valid, 1);
    end
    for (int i = 0; i < 50; i++) begin
      if (spi_clk !== 1'b0 || cs !== 1'b0 || rx_data !== 8'h11 || rx_valid !== 1'b1) stall_bad++;
      step();
    end
    chk("t3_stall", stall_bad, 0);
    rx_ready = 1'b1;
    wait_obs(3, "t3_tmo");
    check_bytes(3, 0, "t3");
    wait_done("t3_done_tmo");
    step();

    // Zero-length read.
    r0 = tot_rises; d0 = done_cnt;
    start(24'h000000, 0);
    chk("t4_done", rd_done, 1);
    chk("t4_busy", rd_busy, 1);
    chk("t4_cs", cs, 1);
    step();
    chk("t4_done_fall", rd_done, 0);
    chk("t4_busy_fall", rd_busy, 0);
    chk("t4_cs2", cs, 1);
    repeat (4) step();
    chk("t4_no_sclk", tot_rises, r0);
    chk("t4_done_cnt", done_cnt, d0 + 1);

    // Reset during address phase, then a clean read.
    set_bytes(32'hDEAD_BEEF, 2, 0);
    start(24'hABCDEF, 2);
    repeat (59) step();
    chk("t5_cs_active", cs, 0);
    rst = 1'b1;
    step();
    chk("t5_cs", cs, 1);
    chk("t5_sclk", spi_clk, 0);
    chk("t5_busy", rd_busy, 0);
    chk("t5_valid", rx_valid, 0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (300) step();
    chk("t5_no_done", done_cnt, d0);
    set_bytes(32'h5A00_0000, 1, 1);
    start(24'h000042, 1);
    wait_obs(1, "t5_tmo");
    check_bytes(1, 1, "t5");
    wait_done("t5_done_tmo");
    chk("t5_cmd", cmd_word, {OPC, 24'h000042});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
